// File: rtl/phase_strobe_gen.sv
// Multi-channel phase strobe generator: a trig rising edge starts a saturating
// phase counter; each channel fires a registered pulse at a programmable offset/width.

module phase_strobe_ch #(
  parameter int CNT_W = 6
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_off,
  input  logic [CNT_W-1:0] i_wid,
  input  logic [CNT_W-1:0] i_cnt,
  input  logic             i_busy,
  output logic             o_strobe
);
  logic             r_en;
  logic [CNT_W-1:0] r_off;
  logic [CNT_W-1:0] r_wid;
  logic [CNT_W:0]   w_end;
  logic             w_hit;

  // One extra bit so off+wid never wraps back into the window.
  assign w_end = {1'b0, r_off} + {1'b0, r_wid};
  assign w_hit = r_en & i_busy & (i_cnt >= r_off) & ({1'b0, i_cnt} < w_end);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_en     <= 1'b0;
      r_off    <= '0;
      r_wid    <= '0;
      o_strobe <= 1'b0;
    end else begin
      if (i_load) begin
        r_en  <= i_en;
        r_off <= i_off;
        r_wid <= i_wid;
      end
      o_strobe <= w_hit;
    end
  end
endmodule

module phase_strobe_gen #(
  parameter int CNT_W  = 6,
  parameter int NUM_CH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_trig,
  input  logic [NUM_CH-1:0]       i_ch_en,
  input  logic [NUM_CH*CNT_W-1:0] i_ch_off,
  input  logic [NUM_CH*CNT_W-1:0] i_ch_wid,
  input  logic                    i_ovr_clr,
  output logic [NUM_CH-1:0]       o_strobe,
  output logic [CNT_W-1:0]        o_phase_cnt,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [7:0]              o_ovr_cnt
);
  localparam logic [CNT_W-1:0] MAX   = '1;
  localparam logic [CNT_W-1:0] MAXM1 = {{(CNT_W-1){1'b1}}, 1'b0};

  logic             r_trig_q;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [7:0]       r_ovr;
  logic             w_edge;
  logic             w_at_end;

  assign w_edge   = i_trig & ~r_trig_q;
  // A counter at MAX-1 only exists inside a live window, so no busy term needed.
  assign w_at_end = (r_cnt == MAXM1) & ~w_edge;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_trig_q <= 1'b0;
      r_cnt    <= MAX;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_trig_q <= i_trig;
      r_done   <= w_at_end;
      if (w_edge) begin
        r_cnt  <= '0;
        r_busy <= 1'b1;
      end else begin
        if (r_cnt != MAX) r_cnt <= r_cnt + 1'b1;
        if (w_at_end)     r_busy <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                              r_ovr <= '0;
    else if (i_ovr_clr)                        r_ovr <= '0;
    else if (w_edge & r_busy & (r_ovr != 8'hFF)) r_ovr <= r_ovr + 8'd1;
  end

  phase_strobe_ch #(.CNT_W(CNT_W)) u_ch [NUM_CH-1:0] (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_load   (w_edge),
    .i_en     (i_ch_en),
    .i_off    (i_ch_off),
    .i_wid    (i_ch_wid),
    .i_cnt    (r_cnt),
    .i_busy   (r_busy),
    .o_strobe (o_strobe)
  );

  assign o_phase_cnt = r_cnt;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_ovr_cnt   = r_ovr;
endmodule

// File: tb/tb_phase_strobe_gen.sv
// Randomized and directed bench for phase_strobe_gen against a timeline model
// (cycles since last trigger edge plus latched channel config).

module tb_phase_strobe_gen;
  localparam int CNT_W  = 6;
  localparam int NUM_CH = 4;
  localparam int MAX    = (1 << CNT_W) - 1;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    trig = 1'b0;
  logic                    ovr_clr = 1'b0;
  logic [NUM_CH-1:0]       ch_en = '0;
  logic [NUM_CH*CNT_W-1:0] ch_off = '0;
  logic [NUM_CH*CNT_W-1:0] ch_wid = '0;
  logic [NUM_CH-1:0]       strobe;
  logic [CNT_W-1:0]        phase_cnt;
  logic                    busy;
  logic                    done;
  logic [7:0]              ovr_cnt;

  phase_strobe_gen #(.CNT_W(CNT_W), .NUM_CH(NUM_CH)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_trig      (trig),
    .i_ch_en     (ch_en),
    .i_ch_off    (ch_off),
    .i_ch_wid    (ch_wid),
    .i_ovr_clr   (ovr_clr),
    .o_strobe    (strobe),
    .o_phase_cnt (phase_cnt),
    .o_busy      (busy),
    .o_done      (done),
    .o_ovr_cnt   (ovr_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: m_j = cycles since the last accepted edge (MAX+1 means idle/never).
  int              m_j;
  bit              m_pt;
  bit [NUM_CH-1:0] m_en;
  int              m_off [NUM_CH];
  int              m_wid [NUM_CH];
  int              m_ovr;
  bit [NUM_CH-1:0] m_stb;

  // Observations relative to the most recent tb-issued trigger.
  int since;
  int rise_at [NUM_CH];
  int stb_cnt [NUM_CH];
  int done_at;
  int done_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_j = MAX + 1;
    m_pt = 1'b0;
    m_en = '0;
    m_ovr = 0;
    m_stb = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_off[i] = 0;
      m_wid[i] = 0;
    end
  endtask

  task automatic clear_obs();
    since = -1;
    done_at = -1;
    done_cnt = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      rise_at[i] = -1;
      stb_cnt[i] = 0;
    end
  endtask

  task automatic tick();
    bit e;
    int c;
    @(posedge clk);
    e = trig && !m_pt;
    c = (m_j > MAX) ? MAX : m_j;
    for (int i = 0; i < NUM_CH; i++)
      m_stb[i] = m_en[i] && (m_j < MAX) && (c >= m_off[i]) && (c < m_off[i] + m_wid[i]);
    if (ovr_clr) m_ovr = 0;
    else if (e && (m_j < MAX) && (m_ovr < 255)) m_ovr++;
    if (e) begin
      m_j = 0;
      m_en = ch_en;
      for (int i = 0; i < NUM_CH; i++) begin
        m_off[i] = int'(ch_off[i*CNT_W +: CNT_W]);
        m_wid[i] = int'(ch_wid[i*CNT_W +: CNT_W]);
      end
    end else if (m_j <= MAX) begin
      m_j++;
    end
    m_pt = trig;
    #1;
    chk("phase_cnt", 32'(phase_cnt), 32'((m_j > MAX) ? MAX : m_j));
    chk("busy", 32'(busy), 32'(m_j < MAX));
    chk("done", 32'(done), 32'(m_j == MAX));
    chk("strobe", 32'(strobe), 32'(m_stb));
    chk("ovr_cnt", 32'(ovr_cnt), 32'(m_ovr));
    since++;
    for (int i = 0; i < NUM_CH; i++) begin
      if (strobe[i] === 1'b1) begin
        stb_cnt[i]++;
        if (rise_at[i] < 0) rise_at[i] = since;
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      if (done_at < 0) done_at = since;
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Leaves the tick that samples the edge as E0 (since == 0).
  task automatic pulse();
    trig = 1'b0;
    tick();
    clear_obs();
    trig = 1'b1;
    tick();
    trig = 1'b0;
  endtask

  task automatic set_ch(input int i, input bit en, input int off, input int wid);
    ch_en[i] = en;
    ch_off[i*CNT_W +: CNT_W] = CNT_W'(off);
    ch_wid[i*CNT_W +: CNT_W] = CNT_W'(wid);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cnt"}, 32'(phase_cnt), 32'(MAX));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_strobe"}, 32'(strobe), 32'd0);
    chk({tag, "_ovr"}, 32'(ovr_cnt), 32'd0);
  endtask

  initial begin
    model_reset();
    clear_obs();
    #12;
    chk_reset_vals("rst");
    rst_n = 1'b1;
    run(3);

    // Legacy three-strobe pattern, ch3 disabled.
    set_ch(0, 1, 5, 1);
    set_ch(1, 1, 8, 1);
    set_ch(2, 1, 10, 1);
    set_ch(3, 0, 3, 4);
    pulse();
    run(70);
    chk("leg_rise0", 32'(rise_at[0]), 32'd6);
    chk("leg_rise1", 32'(rise_at[1]), 32'd9);
    chk("leg_rise2", 32'(rise_at[2]), 32'd11);
    chk("leg_n0", 32'(stb_cnt[0]), 32'd1);
    chk("leg_n1", 32'(stb_cnt[1]), 32'd1);
    chk("leg_n2", 32'(stb_cnt[2]), 32'd1);
    chk("leg_n3", 32'(stb_cnt[3]), 32'd0);
    chk("leg_done_at", 32'(done_at), 32'd63);
    chk("leg_done_n", 32'(done_cnt), 32'd1);

    // Window running past MAX is truncated.
    ch_en = '0;
    set_ch(0, 1, 60, 10);
    pulse();
    run(70);
    chk("trunc_rise", 32'(rise_at[0]), 32'd61);
    chk("trunc_n", 32'(stb_cnt[0]), 32'd3);

    // Retrigger at E0+20.
    set_ch(0, 1, 5, 1);
    set_ch(1, 1, 8, 1);
    set_ch(2, 1, 10, 1);
    pulse();
    run(19);
    clear_obs();
    trig = 1'b1;
    tick();
    trig = 1'b0;
    chk("rt20_cnt", 32'(phase_cnt), 32'd0);
    chk("rt20_ovr", 32'(ovr_cnt), 32'd1);
    run(70);
    chk("rt20_done_n", 32'(done_cnt), 32'd1);
    chk("rt20_done_at", 32'(done_at), 32'd63);
    chk("rt20_rise0", 32'(rise_at[0]), 32'd6);

    // Retrigger sampled while cnt == MAX-1.
    pulse();
    run(MAX - 1);
    trig = 1'b1;
    tick();
    chk("rtm1_done", 32'(done), 32'd0);
    chk("rtm1_ovr", 32'(ovr_cnt), 32'd2);
    trig = 1'b0;
    tick();

    for (int k = 0; k < 256; k++) begin
      trig = 1'b1;
      tick();
      trig = 1'b0;
      tick();
    end
    chk("ovr_sat", 32'(ovr_cnt), 32'd255);

    trig = 1'b1;
    ovr_clr = 1'b1;
    tick();
    chk("ovr_clr", 32'(ovr_cnt), 32'd0);
    ovr_clr = 1'b0;
    trig = 1'b0;
    run(70);

    // Shadow stability and wid=0.
    ch_en = '0;
    set_ch(0, 1, 4, 3);
    set_ch(1, 1, 10, 2);
    set_ch(3, 1, 2, 0);
    pulse();
    run(2);
    set_ch(0, 1, 20, 3);
    set_ch(1, 0, 10, 2);
    run(68);
    chk("sh_rise0", 32'(rise_at[0]), 32'd5);
    chk("sh_n0", 32'(stb_cnt[0]), 32'd3);
    chk("sh_n1", 32'(stb_cnt[1]), 32'd2);
    chk("sh_wid0", 32'(stb_cnt[3]), 32'd0);
    pulse();
    run(70);
    chk("sh2_rise0", 32'(rise_at[0]), 32'd21);
    chk("sh2_n1", 32'(stb_cnt[1]), 32'd0);
    chk("sh2_wid0", 32'(stb_cnt[3]), 32'd0);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 11) == 0) trig = ~trig;
      if ($urandom_range(0, 15) == 0) ch_en = NUM_CH'($urandom);
      if ($urandom_range(0, 15) == 0) ch_off = (NUM_CH*CNT_W)'($urandom);
      if ($urandom_range(0, 15) == 0) ch_wid = (NUM_CH*CNT_W)'($urandom);
      ovr_clr = ($urandom_range(0, 63) == 0);
      tick();
    end
    ovr_clr = 1'b0;
    trig = 1'b0;
    run(70);

    // Async reset mid-window, trig held high across release.
    ch_en = '0;
    set_ch(0, 1, 5, 4);
    pulse();
    run(7);
    chk("ar_cnt7", 32'(phase_cnt), 32'd7);
    chk("ar_stb", 32'(strobe[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    trig = 1'b1;
    #1;
    chk_reset_vals("arst");
    model_reset();
    @(posedge clk);
    #1;
    chk_reset_vals("arst_hold");
    #3;
    rst_n = 1'b1;
    clear_obs();
    tick();
    chk("arel_cnt", 32'(phase_cnt), 32'd0);
    chk("arel_busy", 32'(busy), 32'd1);
    run(70);
    chk("arel_done_at", 32'(done_at), 32'd63);
    chk("arel_done_n", 32'(done_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
